// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, state encodings and iteration count for the multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITERS = 32;
  localparam logic [4:0] MD_LAST_ITER = 5'(MD_ITERS - 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement over 32 bits (upper half zeroed) or 64 bits.
module md_sign_fix (
  input  logic [63:0] value,
  input  logic        wide,
  input  logic        negate,
  output logic [63:0] result
);

  logic [31:0] lo_neg;
  logic [63:0] full_neg;

  always_comb begin
    lo_neg   = ~value[31:0] + 32'd1;
    full_neg = ~value + 64'd1;
    if (wide) result = negate ? full_neg : value;
    else      result = {32'd0, negate ? lo_neg : value[31:0]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO result registers.
// State | meaning: IDLE wait for start / MTHI / MTLO; RUN 32 iterations; FIX sign-correct and write HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  md_state_e   state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] mcand;
  logic        is_div;
  logic        sign_res;
  logic        sign_dvd;

  logic        op_div;
  logic        op_signed;
  logic        in_fix;
  logic [63:0] fix_a_val;
  logic        fix_a_neg;
  logic [63:0] fix_a;
  logic [63:0] fix_b;
  logic [63:0] fix_res;
  logic [32:0] mul_sum;
  logic [32:0] div_diff;
  logic [63:0] acc_next;

  assign op_div    = md_op[1];
  assign op_signed = ~md_op[0];
  assign in_fix    = (state == MD_FIX);

  // The a-side corrector is idle during FIX, so it is reused for the remainder.
  assign fix_a_val = in_fix ? {32'd0, acc[63:32]} : {32'd0, a};
  assign fix_a_neg = in_fix ? sign_dvd : (op_signed & a[31]);

  md_sign_fix u_fix_a (.value(fix_a_val), .wide(1'b0), .negate(fix_a_neg), .result(fix_a));
  md_sign_fix u_fix_b (.value({32'd0, b}), .wide(1'b0), .negate(op_signed & b[31]), .result(fix_b));
  md_sign_fix u_fix_res (.value(acc), .wide(~is_div), .negate(sign_res), .result(fix_res));

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    // acc[63] is the bit shifted out of the remainder; it keeps the trial value 33 bits wide.
    div_diff = acc[63:31] - {1'b0, mcand};
    acc_next = {mul_sum, acc[31:1]};
    if (is_div) begin
      acc_next = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MD_IDLE;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      mcand    <= 32'd0;
      is_div   <= 1'b0;
      sign_res <= 1'b0;
      sign_dvd <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            if (op_div && (b == 32'd0)) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state    <= MD_RUN;
              busy     <= 1'b1;
              cnt      <= 5'd0;
              is_div   <= op_div;
              sign_res <= op_signed & (a[31] ^ b[31]);
              sign_dvd <= op_signed & a[31];
              acc      <= op_div ? fix_a : fix_b;
              mcand    <= op_div ? fix_b[31:0] : fix_a[31:0];
            end
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        MD_RUN: begin
          acc <= acc_next;
          if (cnt == MD_LAST_ITER) begin
            state <= MD_FIX;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        MD_FIX: begin
          lo    <= fix_res[31:0];
          hi    <= is_div ? fix_a[31:0] : fix_res[63:32];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule
